ula_issue: RTL and testbench

- R-type decode/issue/writeback sequencer; initiator side of the ALU interface.
- Accepts 32-bit RV32I instruction words over a valid/ready handshake and decodes opcode/funct3/funct7/rs1/rs2/rd.
- Reads operands from an internal 32x32 register file, presents opcode, funct3, funct7, data1 and data2 to the ALU, captures its result and writes it back to rd.
- Sits between instruction fetch and the ALU; one instruction in flight.

---
 rtl/ula_issue.sv | 143 ++++++++++++++
 tb/tb_ula_issue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_issue.sv
// ula_issue: R-type decode/issue/writeback sequencer acting as the ALU initiator.
// Instructions are accepted one at a time. Each one walks IDLE -> READ -> EXEC -> WB
// and uses an internal register file. Register x0 always reads as zero.
module ula_issue #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [6:0]      alu_opcode,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  output logic [XLEN-1:0] alu_data1,
  output logic [XLEN-1:0] alu_data2,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic [XLEN-1:0] dbg_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t          state;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] regfile [NREGS];

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            handshake;

  // Only R-type ALU ops are legal; funct7=0100000 is valid only for SUB and SRA.
  function automatic logic is_legal(input logic [31:0] w);
    logic op_ok;
    logic f7_ok;
    op_ok = (w[6:0] == 7'b0110011);
    f7_ok = (w[31:25] == 7'b0000000) ||
            ((w[31:25] == 7'b0100000) &&
             ((w[14:12] == 3'b000) || (w[14:12] == 3'b101)));
    return op_ok && f7_ok;
  endfunction

  assign rs1       = instr_q[19:15];
  assign rs2       = instr_q[24:20];
  assign rd        = instr_q[11:7];
  assign rs1_val   = (rs1 == 5'd0) ? '0 : regfile[rs1];
  assign rs2_val   = (rs2 == 5'd0) ? '0 : regfile[rs2];
  assign handshake = instr_valid && instr_ready;
  assign dbg_rdata = (dbg_addr == 5'd0) ? '0 : regfile[dbg_addr];

  // Sequencer FSM. It drives every handshake, ALU and writeback output from registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instr_q     <= 32'd0;
      instr_ready <= 1'b1;
      illegal     <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= '0;
      alu_opcode  <= 7'd0;
      alu_funct3  <= 3'd0;
      alu_funct7  <= 7'd0;
      alu_data1   <= '0;
      alu_data2   <= '0;
    end else begin
      illegal  <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            instr_q     <= instr;
            instr_ready <= 1'b0;
            // The legality result is registered here so the strobe lines up with READ.
            illegal     <= !is_legal(instr);
            state       <= READ;
          end
        end
        READ: begin
          if (is_legal(instr_q)) begin
            alu_opcode <= instr_q[6:0];
            alu_funct3 <= instr_q[14:12];
            alu_funct7 <= instr_q[31:25];
            alu_data1  <= rs1_val;
            alu_data2  <= rs2_val;
            state      <= EXEC;
          end else begin
            instr_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        EXEC: begin
          wb_data    <= alu_result;
          wb_rd      <= rd;
          wb_valid   <= 1'b1;
          alu_opcode <= 7'd0;
          alu_funct3 <= 3'd0;
          alu_funct7 <= 7'd0;
          alu_data1  <= '0;
          alu_data2  <= '0;
          state      <= WB;
        end
        WB: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Register file. It takes writeback in WB and debug preloads only while IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regfile[i] <= '0;
      end
    end else if ((state == WB) && (wb_rd != 5'd0)) begin
      regfile[wb_rd] <= wb_data;
    end else if ((state == IDLE) && dbg_we && (dbg_addr != 5'd0)) begin
      regfile[dbg_addr] <= dbg_wdata;
    end
  end

endmodule

// File: tb/tb_ula_issue.sv
// Scoreboard bench for ula_issue. The stimulus side predicts each result from a
// register-file model and pushes it into a queue. A monitor pops and compares each
// writeback or illegal strobe.
module tb_ula_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;

  ula_issue #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_ill;
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];

  logic [31:0] model [32];

  // RV32I R-type semantics, used both by the ALU stub and by the predictor.
  function automatic logic [31:0] ref_alu(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return f7[5] ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // The ALU stub poisons its result unless a real R-type opcode is presented.
  always_comb begin
    alu_result = (alu_opcode == 7'b0110011)
               ? ref_alu(alu_funct7, alu_funct3, alu_data1, alu_data2) : 32'hDEAD_BEEF;
  end

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Predict the outcome of an instruction accepted in cycle n and update the model.
  task automatic predict(input logic [31:0] w, input int n);
    exp_t e;
    logic [6:0] op; logic [6:0] f7; logic [2:0] f3;
    logic [31:0] a; logic [31:0] b;
    op = w[6:0]; f7 = w[31:25]; f3 = w[14:12];
    e.rd = w[11:7];
    if (op != 7'b0110011 || !(f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)))) begin
      e.is_ill = 1'b1; e.data = 32'd0; e.cyc = n + 1;
    end else begin
      a = (w[19:15] == 5'd0) ? 32'd0 : model[w[19:15]];
      b = (w[24:20] == 5'd0) ? 32'd0 : model[w[24:20]];
      e.is_ill = 1'b0; e.data = ref_alu(f7, f3, a, b); e.cyc = n + 3;
      if (e.rd != 5'd0) model[e.rd] = e.data;
    end
    q.push_back(e);
  endtask

  // Monitor: every writeback or illegal strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (wb_valid || illegal) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {30'd0, wb_valid, illegal}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("out_kind", {30'd0, wb_valid, illegal}, {30'd0, !e.is_ill, e.is_ill});
          chk("out_cycle", cyc, e.cyc);
          if (!e.is_ill) begin
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            chk("wb_data", wb_data, e.data);
          end
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missing_output", 32'd0, 32'd1);
      end
      if (instr_ready) begin
        chk("alu_idle_zero", alu_data1 | alu_data2 | {18'd0, alu_opcode, alu_funct3, alu_funct7}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while ((!instr_ready || q.size() != 0) && g < 50) begin
      @(negedge clk); g++;
    end
    if (g >= 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [31:0] w, input bit dwe, input logic [4:0] da,
                       input logic [31:0] dd, output int acc);
    int g = 0;
    instr = w; instr_valid = 1'b1;
    while (!instr_ready && g < 20) begin
      @(negedge clk); g++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      acc = -1;
      instr_valid = 1'b0;
    end else begin
      dbg_we = dwe; dbg_addr = da; dbg_wdata = dd;
      if (dwe && da != 5'd0) model[da] = dd;
      acc = cyc;
      predict(w, cyc);
      @(negedge clk);
      instr_valid = 1'b0; dbg_we = 1'b0;
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    wait_idle();
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    if (a != 5'd0) model[a] = d;
    @(negedge clk);
    dbg_we = 1'b0;
  endtask

  task automatic peek(input logic [4:0] a);
    dbg_addr = a;
    #1;
    chk("dbg_peek", dbg_rdata, model[a]);
  endtask

  initial begin
    int acc1; int acc2;
    logic [6:0] op; logic [6:0] f7;
    rst = 1'b1; instr_valid = 1'b0; instr = 32'd0;
    dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_alu_data1", alu_data1, 32'd0);
    rst = 1'b0;

    // Directed ADD, SUB, SRA and x0-destination cases.
    preload(5'd1, 32'd5); preload(5'd2, 32'd7);
    issue(32'h002081B3, 1'b0, 5'd0, 32'd0, acc1);
    wait_idle(); peek(5'd3);
    chk("add_x3", model[3], 32'd12);
    preload(5'd1, 32'd0); preload(5'd2, 32'd1);
    issue(enc(7'b0100000, 5'd2, 5'd1, 3'd0, 5'd4, 7'b0110011), 1'b0, 5'd0, 32'd0, acc1);
    wait_idle(); peek(5'd4);
    preload(5'd5, 32'h8000_0000); preload(5'd6, 32'd4);
    issue(enc(7'b0100000, 5'd6, 5'd5, 3'd5, 5'd7, 7'b0110011), 1'b0, 5'd0, 32'd0, acc1);
    wait_idle(); peek(5'd7);
    issue(enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd0, 7'b0110011), 1'b0, 5'd0, 32'd0, acc1);
    wait_idle(); peek(5'd0);

    // Illegal words return to IDLE two cycles after the handshake.
    issue(enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd8, 7'b0010011), 1'b0, 5'd0, 32'd0, acc1);
    issue(enc(7'b0100000, 5'd2, 5'd1, 3'd7, 5'd8, 7'b0110011), 1'b0, 5'd0, 32'd0, acc2);
    chk("illegal_turnaround", acc2 - acc1, 32'd2);
    wait_idle(); peek(5'd8);

    // Back-to-back words. The second word also carries a same-cycle preload of its rs1.
    issue(enc(7'd0, 5'd2, 5'd1, 3'd6, 5'd10, 7'b0110011), 1'b0, 5'd0, 32'd0, acc1);
    issue(enc(7'd0, 5'd2, 5'd11, 3'd0, 5'd12, 7'b0110011), 1'b1, 5'd11, 32'h1234_5678, acc2);
    chk("b2b_spacing", acc2 - acc1, 32'd4);
    // A preload attempted while the DUT is busy must be ignored.
    dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hCAFE_F00D;
    @(negedge clk); dbg_we = 1'b0;
    wait_idle(); peek(5'd9); peek(5'd11); peek(5'd12);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 0) preload(5'($urandom), $urandom);
      op = ($urandom_range(0, 7) == 0) ? 7'b0010011 : 7'b0110011;
      case ($urandom_range(0, 3))
        0, 1:    f7 = 7'd0;
        2:       f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      issue(enc(f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), op),
            ($urandom_range(0, 3) == 0), 5'($urandom), $urandom, acc1);
      if (k % 5 == 4) begin
        wait_idle(); peek(5'($urandom));
      end
    end

    // Reset during EXEC must abandon the instruction and clear the register file.
    wait_idle();
    preload(5'd1, 32'd3);
    issue(32'h002081B3, 1'b0, 5'd0, 32'd0, acc1);
    @(negedge clk);
    rst = 1'b1; q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    repeat (4) @(negedge clk);
    peek(5'd1); peek(5'd3); peek(5'd5);

    wait_idle();
    chk("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
